// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// with glitch-free runtime increment retune and a PLL-style lock indicator.
module frac_clken_gen #(
  parameter int unsigned               CHANNELS    = 4,
  parameter int unsigned               ACC_W       = 32,
  parameter int unsigned               CHAN_W      = 2,
  parameter int unsigned               LOCK_CYCLES = 256,
  parameter logic [CHANNELS*ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic                cfg_phase_rst,
  output logic [CHANNELS-1:0] ce_out,
  output logic                locked
);

  localparam int unsigned     LC_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {S_LOCKING, S_LOCKED, S_PENDING} state_t;
  state_t r_state, w_state_nxt;

  logic [ACC_W-1:0]    r_acc [CHANNELS];
  logic [ACC_W-1:0]    r_inc [CHANNELS];
  logic [CHANNELS-1:0] r_ce;
  logic [LC_W-1:0]     r_lock_cnt;
  logic [CHAN_W-1:0]   r_pend_chan;
  logic [ACC_W-1:0]    r_pend_inc;

  logic [ACC_W-1:0]    w_sum [CHANNELS];
  logic [CHANNELS-1:0] w_carry;
  logic [CHANNELS-1:0] w_inc_zero;
  logic [CHANNELS-1:0] w_pend_sel;
  logic                w_run, w_accept, w_phase_rst, w_pend_apply;

  assign w_run       = enable && (r_state != S_LOCKING);
  assign w_accept    = cfg_valid && (r_state == S_LOCKED);
  assign w_phase_rst = w_accept && cfg_phase_rst;

  always_comb begin
    w_carry    = '0;
    w_inc_zero = '0;
    w_pend_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      {w_carry[i], w_sum[i]} = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      w_inc_zero[i] = (r_inc[i] == '0);
      w_pend_sel[i] = (32'(r_pend_chan) == i);
    end
  end

  // An out-of-range channel selects nothing and is dropped at once; a zero
  // increment never carries, so it is swapped immediately instead of stalling.
  assign w_pend_apply = (w_pend_sel == '0) ||
                        ((w_pend_sel & (w_inc_zero | (w_run ? w_carry : '0))) != '0);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOCKING;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOCKING: if (r_lock_cnt == LC_LAST) w_state_nxt = S_LOCKED;
      S_LOCKED:  if (w_accept) w_state_nxt = cfg_phase_rst ? S_LOCKING : S_PENDING;
      S_PENDING: if (w_pend_apply) w_state_nxt = S_LOCKED;
      default:   w_state_nxt = S_LOCKING;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
        r_inc[i] <= DEFAULT_INC[i*ACC_W +: ACC_W];
      end
      r_ce        <= '0;
      r_lock_cnt  <= '0;
      r_pend_chan <= '0;
      r_pend_inc  <= '0;
    end else begin
      r_lock_cnt <= (r_state == S_LOCKING && r_lock_cnt != LC_LAST) ? r_lock_cnt + 1'b1 : '0;
      if (w_phase_rst) begin
        r_ce <= '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          r_acc[i] <= '0;
          if (32'(cfg_chan) == i) r_inc[i] <= cfg_inc;
        end
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (r_state == S_LOCKING) r_acc[i] <= '0;
          else if (enable)          r_acc[i] <= w_sum[i];
          r_ce[i] <= w_run && w_carry[i];
          // The wrapping add above still uses the old increment.
          if (r_state == S_PENDING && w_pend_apply && w_pend_sel[i]) r_inc[i] <= r_pend_inc;
        end
      end
      if (w_accept) begin
        r_pend_chan <= cfg_chan;
        r_pend_inc  <= cfg_inc;
      end
    end
  end

  assign ce_out    = r_ce;
  assign locked    = (r_state != S_LOCKING);
  assign cfg_ready = (r_state == S_LOCKED);

endmodule

// File: tb/tb_frac_clken_gen.sv
// Self-checking bench for frac_clken_gen: directed scenarios plus random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_frac_clken_gen;
  localparam int NCH = 4;
  localparam int LC  = 16;
  localparam int MOD = 256;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_phase_rst = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_inc = '0;
  logic       cfg_ready, locked;
  logic [3:0] ce_out;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int       m_acc [NCH];
  int       m_inc [NCH];
  logic [3:0] m_ce;
  bit       m_locked, m_ready, m_pend;
  int       m_lock_left, m_pch, m_pinc;

  frac_clken_gen #(
    .CHANNELS(4), .ACC_W(8), .CHAN_W(2), .LOCK_CYCLES(16),
    .DEFAULT_INC(32'h0000_0040)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_inc(cfg_inc), .cfg_phase_rst(cfg_phase_rst),
    .ce_out(ce_out), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
    m_inc[0] = 64; m_inc[1] = 0; m_inc[2] = 0; m_inc[3] = 0;
    m_ce = '0; m_locked = 0; m_ready = 0; m_pend = 0;
    m_lock_left = LC; m_pch = 0; m_pinc = 0;
  endtask

  task automatic model_edge();
    bit wrap [NCH];
    bit acc_ok;
    int s;
    acc_ok = cfg_valid && m_ready;
    if (!m_locked) begin
      m_ce = '0;
      for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      m_lock_left--;
      if (m_lock_left == 0) begin m_locked = 1; m_ready = 1; end
    end else if (acc_ok && cfg_phase_rst) begin
      m_inc[int'(cfg_chan)] = int'(cfg_inc);
      for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      m_ce = '0; m_locked = 0; m_ready = 0; m_lock_left = LC;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s = m_acc[i] + m_inc[i];
        wrap[i] = enable && (s >= MOD);
        if (enable) m_acc[i] = s % MOD;
        m_ce[i] = wrap[i];
      end
      if (m_pend) begin
        if (m_pch >= NCH) m_pend = 0;
        else if (m_inc[m_pch] == 0 || wrap[m_pch]) begin
          m_inc[m_pch] = m_pinc;
          m_pend = 0;
        end
        if (!m_pend) m_ready = 1;
      end
      if (acc_ok) begin
        m_pend = 1; m_ready = 0;
        m_pch = int'(cfg_chan); m_pinc = int'(cfg_inc);
      end
    end
  endtask

  task automatic step();
    @(posedge refclk);
    if (rst_n) model_edge();
    #1;
    check("ce_out", 32'(ce_out), 32'(m_ce));
    check("locked", 32'(locked), 32'(m_locked));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic cfg_req(input logic [1:0] ch, input logic [7:0] inc, input logic pr);
    int  n;
    bit  done;
    n = 0; done = 0;
    cfg_valid = 1'b1; cfg_chan = ch; cfg_inc = inc; cfg_phase_rst = pr;
    while (!done && n < 200) begin
      done = m_ready;
      step();
      n++;
    end
    cfg_valid = 1'b0;
    cfg_phase_rst = 1'b0;
    check("cfg_accept", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int cnt;
    model_reset();
    repeat (3) step();

    // Release reset and measure lock latency
    enable = 1'b1;
    @(negedge refclk);
    rst_n = 1'b1;
    n = 0;
    while (!locked && n < 100) begin step(); n++; end
    check("lock_latency", 32'(n), 32'd16);
    repeat (20) step();

    // Retune an idle channel (old inc 0), then a running one mid-period
    cfg_req(2'd1, 8'd128, 1'b0);
    repeat (20) step();
    repeat (1 + $urandom_range(0, 3)) step();
    cfg_req(2'd0, 8'd32, 1'b0);
    repeat (30) step();

    // Phase reset relocks and realigns
    cfg_req(2'd0, 8'd64, 1'b1);
    repeat (40) step();

    // Enable gap mid-period
    repeat ($urandom_range(1, 3)) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    repeat (20) step();

    // Near-maximal increment: 255 pulses in any 256-cycle window
    cfg_req(2'd2, 8'd255, 1'b0);
    repeat (5) step();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (ce_out[2]) cnt++;
    end
    check("ch2_pulses_256", 32'(cnt), 32'd255);

    // Stalled pending update (enable low) aborted by async reset
    enable = 1'b0;
    cfg_req(2'd0, 8'd16, 1'b0);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ce_out", 32'(ce_out), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (3) step();
    enable = 1'b1;
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (40) step();

    // Random traffic
    repeat (1500) begin
      enable        = ($urandom_range(0, 9) != 0);
      cfg_valid     = ($urandom_range(0, 3) == 0);
      cfg_chan      = 2'($urandom);
      cfg_inc       = 8'($urandom);
      cfg_phase_rst = ($urandom_range(0, 15) == 0);
      step();
    end
    cfg_valid = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
